// File: rtl/ramio_arbiter.sv
// Two-requester arbiter for a shared memory-mapped port: round-robin grant, optional
// lock ownership bounded by LOCK_MAX cycles, and one-cycle-latency read return routing.
module ramio_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic [1:0]            m0_we,
    input  logic [2:0]            m0_re,
    input  logic [ADDR_WIDTH+1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_din,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_dout,
    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic [1:0]            m1_we,
    input  logic [2:0]            m1_re,
    input  logic [ADDR_WIDTH+1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_din,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_dout,
    output logic [1:0]            weA,
    output logic [2:0]            reA,
    output logic [ADDR_WIDTH+1:0] addrA,
    output logic [DATA_WIDTH-1:0] dinA,
    input  logic [DATA_WIDTH-1:0] doutA,
    output logic                  lock_err
);

    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state_r;
    logic          ptr_r;        // last requester granted; 1 after reset so m0 wins first tie
    logic [CW-1:0] cnt_r;
    logic          pend_valid_r;
    logic          pend_id_r;

    logic          gnt0_s;
    logic          gnt1_s;
    logic          own_lock_s;
    logic          lock_err_s;
    logic [1:0]    we_sel_s;
    logic [2:0]    re_sel_s;
    logic          rd_issue_s;

    // Grant selection: owner-exclusive while locked, round-robin on ties when idle
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        gnt0_s = ptr_r;
                        gnt1_s = ~ptr_r;
                    end else begin
                        gnt0_s = m0_req;
                        gnt1_s = m1_req;
                    end
                end
                OWN0:    gnt0_s = m0_req;
                OWN1:    gnt1_s = m1_req;
                default: gnt0_s = 1'b0;
            endcase
        end
    end

    // Forced release fires only when the owner still wants to keep the lock at the limit
    always_comb begin
        own_lock_s = 1'b0;
        case (state_r)
            OWN0:    own_lock_s = m0_lock;
            OWN1:    own_lock_s = m1_lock;
            default: own_lock_s = 1'b0;
        endcase
        lock_err_s = !rst && (state_r != IDLE) && own_lock_s && (cnt_r == CNT_LAST);
    end

    // Downstream port mux; a combined write+read request issues only the write
    always_comb begin
        we_sel_s = 2'b00;
        re_sel_s = 3'b000;
        addrA    = '0;
        dinA     = '0;
        if (gnt0_s) begin
            we_sel_s = m0_we;
            re_sel_s = m0_re;
            addrA    = m0_addr;
            dinA     = m0_din;
        end else if (gnt1_s) begin
            we_sel_s = m1_we;
            re_sel_s = m1_re;
            addrA    = m1_addr;
            dinA     = m1_din;
        end else begin
            we_sel_s = 2'b00;
        end
        weA        = we_sel_s;
        reA        = (we_sel_s != 2'b00) ? 3'b000 : re_sel_s;
        rd_issue_s = (gnt0_s || gnt1_s) && (re_sel_s != 3'b000) && (we_sel_s == 2'b00);
    end

    // Ownership state, round-robin pointer, lock counter and read-pending tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            ptr_r        <= 1'b1;
            cnt_r        <= '0;
            pend_valid_r <= 1'b0;
            pend_id_r    <= 1'b0;
        end else begin
            pend_valid_r <= rd_issue_s;
            pend_id_r    <= gnt1_s;
            if (gnt0_s) begin
                ptr_r <= 1'b0;
            end else if (gnt1_s) begin
                ptr_r <= 1'b1;
            end else begin
                ptr_r <= ptr_r;
            end
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (gnt0_s && m0_lock) begin
                        state_r <= OWN0;
                    end else if (gnt1_s && m1_lock) begin
                        state_r <= OWN1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                OWN0, OWN1: begin
                    if (lock_err_s) begin
                        state_r <= IDLE;
                        ptr_r   <= (state_r == OWN1);
                        cnt_r   <= '0;
                    end else if (!own_lock_s) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1'b1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign m0_gnt    = gnt0_s;
    assign m1_gnt    = gnt1_s;
    assign lock_err  = lock_err_s;
    assign m0_rvalid = pend_valid_r && !pend_id_r && !rst;
    assign m1_rvalid = pend_valid_r && pend_id_r && !rst;
    assign m0_dout   = m0_rvalid ? doutA : '0;
    assign m1_dout   = m1_rvalid ? doutA : '0;

endmodule

// File: tb/tb_ramio_arbiter.sv
// Self-checking bench for ramio_arbiter: directed scenarios plus randomized traffic
// against a cycle-level ownership/round-robin reference model.
module tb_ramio_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    req, lock;
    logic [1:0]    we [2];
    logic [2:0]    re [2];
    logic [AW+1:0] addr [2];
    logic [DW-1:0] din [2];
    logic [DW-1:0] doutA;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, lock_err;
    logic [DW-1:0] m0_dout, m1_dout, dinA;
    logic [1:0]    weA;
    logic [2:0]    reA;
    logic [AW+1:0] addrA;

    ramio_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_lock(lock[0]), .m0_we(we[0]), .m0_re(re[0]),
        .m0_addr(addr[0]), .m0_din(din[0]), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_dout(m0_dout),
        .m1_req(req[1]), .m1_lock(lock[1]), .m1_we(we[1]), .m1_re(re[1]),
        .m1_addr(addr[1]), .m1_din(din[1]), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_dout(m1_dout),
        .weA(weA), .reA(reA), .addrA(addrA), .dinA(dinA), .doutA(doutA), .lock_err(lock_err)
    );

    // Reference model: owner index (-1 none), last granted, pending reader, cycles held
    int owner, last, pend, held, m_g;
    logic [1:0]    e_gnt, e_rv, e_we;
    logic [2:0]    e_re;
    logic [AW+1:0] e_addr;
    logic [DW-1:0] e_din, e_d0, e_d1;
    logic          e_err;
    int n_cmp = 0;
    int n_fail = 0;

    task automatic model_eval();
        e_gnt = 2'b00; e_rv = 2'b00; e_we = 2'b00; e_re = 3'b000;
        e_addr = '0; e_din = '0; e_d0 = '0; e_d1 = '0; e_err = 1'b0; m_g = -1;
        if (!rst) begin
            if (pend == 0) begin e_rv = 2'b01; e_d0 = doutA; end
            if (pend == 1) begin e_rv = 2'b10; e_d1 = doutA; end
            if (owner >= 0) begin
                if (req[owner]) m_g = owner;
            end else if (req == 2'b11) m_g = (last == 0) ? 1 : 0;
            else if (req[0]) m_g = 0;
            else if (req[1]) m_g = 1;
            if (m_g >= 0) begin
                e_gnt[m_g] = 1'b1;
                e_we = we[m_g];
                e_re = (we[m_g] != 2'b00) ? 3'b000 : re[m_g];
                e_addr = addr[m_g];
                e_din = din[m_g];
            end
            e_err = (owner >= 0) && lock[owner] && (held == LM);
        end
    endtask

    task automatic model_commit();
        if (rst) begin
            owner = -1; last = 1; pend = -1; held = 0;
        end else begin
            pend = (m_g >= 0 && re[m_g] != 3'b000 && we[m_g] == 2'b00) ? m_g : -1;
            if (m_g >= 0) last = m_g;
            if (owner >= 0) begin
                if (e_err) begin last = owner; owner = -1; held = 0; end
                else if (!lock[owner]) begin owner = -1; held = 0; end
                else held++;
            end else if (m_g >= 0 && lock[m_g]) begin
                owner = m_g; held = 1;
            end
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w0,
                         input logic [2:0] r0, input logic [1:0] w1, input logic [2:0] r1);
        req = r; lock = l; we[0] = w0; re[0] = r0; we[1] = w1; re[1] = r1;
        addr[0] = 18'($urandom); addr[1] = 18'($urandom);
        din[0] = $urandom; din[1] = $urandom; doutA = $urandom;
    endtask

    task automatic settle();
        model_eval();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'b11, 2'b11, 3'b010, 2'b00, 3'b010);
            settle();
            n_cmp++;
            if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, lock_err} !== 5'b0 || weA !== 2'b00 ||
                reA !== 3'b000 || addrA !== '0 || dinA !== '0 || m0_dout !== '0 || m1_dout !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got gnt=%b rv=%b err=%b we=%b re=%b addr=%h, need all zero",
                         {m1_gnt, m0_gnt}, {m1_rvalid, m0_rvalid}, lock_err, weA, reA, addrA);
            end
            advance();
        end
    endtask

    task automatic test_rr_reads();
        logic [1:0] prev = 2'b00;
        logic [1:0] want;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 2'b00, 2'b00, 3'b010, 2'b00, 3'b010);
            addr[0] = 18'h10; addr[1] = 18'h20;
            settle();
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if ({m1_gnt, m0_gnt} !== want || addrA !== ((i % 2 == 0) ? 18'h10 : 18'h20)) begin
                n_fail++;
                $display("FAIL rr_grant cyc %0d: got gnt=%b addr=%h, need gnt=%b", i, {m1_gnt, m0_gnt}, addrA, want);
            end
            n_cmp++;
            if ({m1_rvalid, m0_rvalid} !== prev || m0_dout !== (prev[0] ? doutA : 32'h0) ||
                m1_dout !== (prev[1] ? doutA : 32'h0)) begin
                n_fail++;
                $display("FAIL rr_rvalid cyc %0d: got rv=%b d0=%h d1=%h, need rv=%b doutA=%h",
                         i, {m1_rvalid, m0_rvalid}, m0_dout, m1_dout, prev, doutA);
            end
            prev = want;
            advance();
        end
    endtask

    task automatic test_lock();
        logic [1:0] want [6] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        for (int i = 0; i < 6; i++) begin
            if (i == 0) drive(2'b10, 2'b00, 2'b00, 3'b000, 2'b00, 3'b010);
            else drive(2'b11, (i >= 1 && i <= 3) ? 2'b01 : 2'b00, 2'b11, 3'b000, 2'b00, 3'b010);
            settle();
            n_cmp++;
            if ({m1_gnt, m0_gnt} !== want[i] || lock_err !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_hold cyc %0d: got gnt=%b err=%b, need gnt=%b err=0", i, {m1_gnt, m0_gnt}, lock_err, want[i]);
            end
            advance();
        end
    endtask

    task automatic test_lock_max();
        logic [1:0] want_g [7] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        logic       want_e [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            if (i == 0) drive(2'b10, 2'b00, 2'b00, 3'b000, 2'b00, 3'b010);
            else drive(2'b11, 2'b01, 2'b11, 3'b000, 2'b00, 3'b010);
            settle();
            n_cmp++;
            if ({m1_gnt, m0_gnt} !== want_g[i] || lock_err !== want_e[i]) begin
                n_fail++;
                $display("FAIL lock_max cyc %0d: got gnt=%b err=%b, need gnt=%b err=%b",
                         i, {m1_gnt, m0_gnt}, lock_err, want_g[i], want_e[i]);
            end
            advance();
        end
    endtask

    task automatic test_overlap();
        drive(2'b10, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001);
        settle();
        advance();
        drive(2'b01, 2'b00, 2'b11, 3'b000, 2'b00, 3'b000);
        settle();
        n_cmp++;
        if (m1_rvalid !== 1'b1 || m1_dout !== doutA || m0_rvalid !== 1'b0 || weA !== 2'b11 || m0_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL read_then_write: got m1_rv=%b m1_dout=%h m0_rv=%b weA=%b m0_gnt=%b, need 1 %h 0 11 1",
                     m1_rvalid, m1_dout, m0_rvalid, weA, m0_gnt, doutA);
        end
        advance();
    endtask

    task automatic test_we_re();
        drive(2'b01, 2'b00, 2'b01, 3'b001, 2'b00, 3'b000);
        settle();
        n_cmp++;
        if (weA !== 2'b01 || reA !== 3'b000) begin
            n_fail++;
            $display("FAIL we_re_issue: got weA=%b reA=%b, need 01 000", weA, reA);
        end
        advance();
        drive(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000);
        settle();
        n_cmp++;
        if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL we_re_rvalid: got rv=%b, need 00", {m1_rvalid, m0_rvalid});
        end
        advance();
    endtask

    task automatic test_reset_pending();
        drive(2'b01, 2'b01, 2'b00, 3'b010, 2'b00, 3'b000);
        settle();
        advance();
        drive(2'b01, 2'b01, 2'b00, 3'b010, 2'b00, 3'b000);
        settle();
        advance();
        rst = 1'b1;
        drive(2'b11, 2'b01, 2'b00, 3'b010, 2'b00, 3'b010);
        settle();
        n_cmp++;
        if (m0_rvalid !== 1'b0 || lock_err !== 1'b0 || m0_dout !== '0 || {m1_gnt, m0_gnt} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_pending: got rv0=%b err=%b dout0=%h gnt=%b, need 0 0 0 00",
                     m0_rvalid, lock_err, m0_dout, {m1_gnt, m0_gnt});
        end
        advance();
        rst = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 3'b010, 2'b00, 3'b010);
        settle();
        n_cmp++;
        if ({m1_gnt, m0_gnt} !== 2'b01 || m0_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tie: got gnt=%b rv0=%b, need gnt=01 rv0=0", {m1_gnt, m0_gnt}, m0_rvalid);
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive(2'($urandom), ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom),
                  ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom), 3'($urandom),
                  ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom), 3'($urandom));
            settle();
            n_cmp++;
            if ({m1_gnt, m0_gnt} !== e_gnt || {m1_rvalid, m0_rvalid} !== e_rv || m0_dout !== e_d0 ||
                m1_dout !== e_d1 || weA !== e_we || reA !== e_re || addrA !== e_addr ||
                dinA !== e_din || lock_err !== e_err) begin
                n_fail++;
                $display("FAIL random cyc %0d: got gnt=%b rv=%b err=%b we=%b re=%b addr=%h din=%h d0=%h d1=%h need gnt=%b rv=%b err=%b we=%b re=%b addr=%h din=%h d0=%h d1=%h",
                         i, {m1_gnt, m0_gnt}, {m1_rvalid, m0_rvalid}, lock_err, weA, reA, addrA, dinA, m0_dout, m1_dout,
                         e_gnt, e_rv, e_err, e_we, e_re, e_addr, e_din, e_d0, e_d1);
            end
            advance();
        end
    endtask

    initial begin
        owner = -1; last = 1; pend = -1; held = 0; m_g = -1;
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000);
        #1;
        test_reset();
        test_rr_reads();
        test_lock();
        test_lock_max();
        test_overlap();
        test_we_re();
        test_reset_pending();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ramio_arbiter.md
RAMIO_ARBITER -- requirements
Module: ramio_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, word-address width of the shared memory-mapped port (byte address is ADDR_WIDTH+2 bits).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter LOCK_MAX, default 64, maximum consecutive cycles one requester may hold a lock.
REQ-004 clk  in  1  clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 mN_req  in  1  requester N (N=0,1) wants the port this cycle.
REQ-007 mN_lock  in  1  requester N asks to keep ownership after this access.
REQ-008 mN_we  in  2  write size (00 none, 01 byte, 10 half, 11 word).
REQ-009 mN_re  in  3  read size, bit 2 sign-extend (same encoding as downstream reA).
REQ-010 mN_addr  in  ADDR_WIDTH+2  byte address.
REQ-011 mN_din  in  DATA_WIDTH  write data.
REQ-012 mN_gnt  out  1  access issued downstream this cycle for requester N.
REQ-013 mN_rvalid  out  1  read data for requester N valid this cycle.
REQ-014 mN_dout  out  DATA_WIDTH  read data for requester N.
REQ-015 weA  out  2, reA  out  3, addrA  out  ADDR_WIDTH+2, dinA  out  DATA_WIDTH  shared downstream port.
REQ-016 doutA  in  DATA_WIDTH  downstream read data, valid one cycle after read issue.
REQ-017 lock_err  out  1  one-cycle pulse on forced lock release.

Function
REQ-018 Grant SHALL be combinational in the request cycle; granted requester's we/re/addr/din SHALL drive downstream unchanged that cycle.
REQ-019 No grant: weA=0, reA=0, addrA=0, dinA=0.
REQ-020 At most one mN_gnt high per cycle; mN_gnt SHALL never assert without mN_req.
REQ-021 State machine states IDLE, OWN0, OWN1; reset state IDLE.
REQ-022 IDLE, one requester: grant it.
REQ-023 IDLE, both requesting: grant requester not granted most recently (round-robin pointer); pointer reset value SHALL make m0 win the first tie.
REQ-024 Pointer SHALL update to N on every cycle mN_gnt=1.
REQ-025 IDLE -> OWNN when mN granted with mN_lock=1.
REQ-026 OWNN: only mN may be granted; other requester stalls (gnt=0) regardless of pointer.
REQ-027 OWNN -> IDLE when mN granted with mN_lock=0, or when mN_req=0 and mN_lock=0.
REQ-028 OWNN with mN_req=0, mN_lock=1: port idle, state held.
REQ-029 Lock counter SHALL clear on entering OWNN and increment each cycle in OWNN.
REQ-030 Counter reaching LOCK_MAX-1 in OWNN: next state IDLE, lock_err=1 for that one cycle, pointer set to N so other requester wins next tie; no access is aborted.
REQ-031 Request with both we!=0 and re!=0: write issued, reA forced 0, no rvalid.
REQ-032 Granted read (re!=0, we=0): pending register captures owner; next cycle mN_rvalid=1 and mN_dout=doutA for that owner only.
REQ-033 Non-owner mN_dout SHALL be 0; mN_dout 0 whenever mN_rvalid=0.
REQ-034 Back-to-back reads (either requester, every cycle) SHALL be supported at full rate; rvalid for cycle-k grant in cycle k+1 regardless of grant in k+1.
REQ-035 Writes SHALL produce no rvalid; write completes in grant cycle.

Reset
REQ-036 rst=1 on a clock edge: state IDLE, pointer favours m0, lock counter 0, read pending cleared.
REQ-037 During and after reset edge: all mN_gnt, mN_rvalid, lock_err 0; mN_dout 0; downstream idle values per REQ-019 while rst=1.
REQ-038 Reset during a pending read SHALL suppress its rvalid; reset during OWNN SHALL release lock without lock_err.

Verification
REQ-039 Both req reads every cycle from reset, addrs 0x10/0x20 -> gnt alternates m0,m1,m0...; rvalid each follows its grant by one cycle with matching doutA.
REQ-040 m0 lock=1 three word writes, m1 req throughout -> m1 gnt=0 for all three; m1 granted cycle after m0 lock=0 access.
REQ-041 LOCK_MAX=4, m0 holds lock, req continuous -> lock_err pulse in 4th OWN0 cycle; m1 granted next cycle.
REQ-042 m1 lbu read at cycle k, m0 sw at k+1 -> m1_rvalid=1 at k+1 with doutA, m0_rvalid=0, weA=11 at k+1.
REQ-043 m0 we=01 and re=001 simultaneously -> weA=01, reA=000, no rvalid next cycle.
REQ-044 rst asserted cycle after m0 read grant while OWN0 -> m0_rvalid=0, lock_err=0, state IDLE, m0 wins next tie.
